// File: rtl/naval_pkg.sv
// Shared encodings and map indexing for the naval battle controller.
package naval_pkg;

   typedef enum logic [1:0] {
      PH_IDLE   = 2'b00,
      PH_PLACE  = 2'b01,
      PH_ATTACK = 2'b10,
      PH_OVER   = 2'b11
   } phase_e;

   typedef enum logic [1:0] {
      RES_NONE = 2'b00,
      RES_MISS = 2'b01,
      RES_HIT  = 2'b10,
      RES_REJ  = 2'b11
   } result_e;

   // Row 0 / col 0 (top-left) lives in the MSB of the flat map.
   function automatic int unsigned bit_idx(
      input int unsigned r,
      input int unsigned c,
      input int unsigned rows,
      input int unsigned cols
   );
      return (rows - 1 - r) * cols + (cols - 1 - c);
   endfunction

endpackage

// File: rtl/naval_matrix_scan.sv
// Column scanner: prescaled column counter, one-hot select, column slice.
module naval_matrix_scan #(
   parameter int ROWS     = 7,
   parameter int COLS     = 5,
   parameter int SCAN_DIV = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [ROWS*COLS-1:0] map_i,
   output logic [COLS-1:0]      m_col_o,
   output logic [ROWS-1:0]      m_line_o
);

   localparam int CW = $clog2(COLS);

   logic [SCAN_DIV-1:0] presc_q, presc_d;
   logic [CW-1:0]       col_q, col_d;
   logic [COLS-1:0]     m_col_q, m_col_d;

   always_comb begin
      presc_d = presc_q + SCAN_DIV'(1);
      col_d   = col_q;
      m_col_d = m_col_q;
      if (presc_q == '1) begin
         col_d   = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
         m_col_d = {m_col_q[COLS-2:0], m_col_q[COLS-1]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_q <= '0;
         col_q   <= '0;
         m_col_q <= COLS'(1);
      end else begin
         presc_q <= presc_d;
         col_q   <= col_d;
         m_col_q <= m_col_d;
      end
   end

   always_comb begin
      m_line_o = '0;
      for (int c = 0; c < COLS; c++) begin
         if (col_q == CW'(c)) begin
            for (int j = 0; j < ROWS; j++) begin
               m_line_o[j] = map_i[j*COLS + COLS - 1 - c];
            end
         end
      end
   end

   assign m_col_o = m_col_q;

endmodule

// File: rtl/naval_battle_ctrl.sv
// Naval battle game controller: confirm edge detect, phase FSM,
// attack map, hit/shot bookkeeping and matrix display selection.
module naval_battle_ctrl
   import naval_pkg::*;
#(
   parameter int ROWS      = 7,
   parameter int COLS      = 5,
   parameter int MAX_SHOTS = 16,
   parameter int SCAN_DIV  = 16
) (
   input  logic                               clk,
   input  logic                               clr,
   input  logic                               confirm,
   input  logic [ROWS*COLS-1:0]               ship_map,
   input  logic [$clog2(ROWS)-1:0]            at_row,
   input  logic [$clog2(COLS)-1:0]            at_col,
   output logic [COLS-1:0]                    m_col,
   output logic [ROWS-1:0]                    m_line,
   output logic [1:0]                         result,
   output logic [1:0]                         phase,
   output logic                               won,
   output logic [$clog2(ROWS*COLS+1)-1:0]     hits,
   output logic [$clog2(MAX_SHOTS+1)-1:0]     shots_left
);

   localparam int N  = ROWS * COLS;
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int IW = $clog2(N);
   localparam int HW = $clog2(N + 1);
   localparam int SW = $clog2(MAX_SHOTS + 1);
   localparam logic [RW:0] ROWS_L = (RW + 1)'(ROWS);
   localparam logic [CW:0] COLS_L = (CW + 1)'(COLS);

   phase_e        state_q, state_d;
   result_e       res_q, res_d;
   logic [N-1:0]  ship_q, ship_d;
   logic [N-1:0]  att_q, att_d;
   logic [HW-1:0] fleet_q, fleet_d;
   logic [HW-1:0] hits_q, hits_d;
   logic [SW-1:0] shots_q, shots_d;
   logic          won_q, won_d;
   logic          conf_q, conf_prev_q;

   logic          pulse;
   logic [HW-1:0] pc;
   logic          in_rng;
   logic [IW-1:0] idx;
   logic [N-1:0]  disp;

   assign pulse = conf_q & ~conf_prev_q;

   always_comb begin
      pc = '0;
      for (int i = 0; i < N; i++) begin
         pc = pc + HW'(ship_map[i]);
      end
   end

   assign in_rng = ({1'b0, at_row} < ROWS_L) && ({1'b0, at_col} < COLS_L);
   assign idx    = IW'(bit_idx(32'(at_row), 32'(at_col), ROWS, COLS));

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      ship_d  = ship_q;
      att_d   = att_q;
      fleet_d = fleet_q;
      hits_d  = hits_q;
      shots_d = shots_q;
      won_d   = won_q;
      if (pulse) begin
         unique case (state_q)
            PH_IDLE: state_d = PH_PLACE;
            PH_PLACE: begin
               if (pc == '0) begin
                  res_d = RES_REJ;
               end else begin
                  ship_d  = ship_map;
                  fleet_d = pc;
                  att_d   = '0;
                  hits_d  = '0;
                  shots_d = SW'(MAX_SHOTS);
                  res_d   = RES_NONE;
                  state_d = PH_ATTACK;
               end
            end
            PH_ATTACK: begin
               if (!in_rng || att_q[idx]) begin
                  res_d = RES_REJ;
               end else begin
                  att_d[idx] = 1'b1;
                  shots_d    = shots_q - SW'(1);
                  if (ship_q[idx]) begin
                     hits_d = hits_q + HW'(1);
                     res_d  = RES_HIT;
                  end else begin
                     res_d  = RES_MISS;
                  end
                  // A final shot that sinks the fleet counts as a win.
                  if (hits_d == fleet_q) begin
                     state_d = PH_OVER;
                     won_d   = 1'b1;
                  end else if (shots_d == '0) begin
                     state_d = PH_OVER;
                     won_d   = 1'b0;
                  end
               end
            end
            PH_OVER: begin
               state_d = PH_IDLE;
               res_d   = RES_NONE;
               hits_d  = '0;
               won_d   = 1'b0;
               att_d   = '0;
            end
            default: state_d = PH_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q     <= PH_IDLE;
         res_q       <= RES_NONE;
         ship_q      <= '0;
         att_q       <= '0;
         fleet_q     <= '0;
         hits_q      <= '0;
         shots_q     <= '0;
         won_q       <= 1'b0;
         conf_q      <= 1'b0;
         conf_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         res_q       <= res_d;
         ship_q      <= ship_d;
         att_q       <= att_d;
         fleet_q     <= fleet_d;
         hits_q      <= hits_d;
         shots_q     <= shots_d;
         won_q       <= won_d;
         conf_q      <= confirm;
         conf_prev_q <= conf_q;
      end
   end

   always_comb begin
      disp = '0;
      unique case (state_q)
         PH_IDLE:   disp = '0;
         PH_PLACE:  disp = ship_map;
         PH_ATTACK: disp = att_q;
         PH_OVER:   disp = ship_q | att_q;
         default:   disp = '0;
      endcase
   end

   naval_matrix_scan #(
      .ROWS     (ROWS),
      .COLS     (COLS),
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk_i    (clk),
      .rst_ni   (clr),
      .map_i    (disp),
      .m_col_o  (m_col),
      .m_line_o (m_line)
   );

   assign result     = res_q;
   assign phase      = state_q;
   assign won        = won_q;
   assign hits       = hits_q;
   assign shots_left = shots_q;

endmodule

// File: tb/tb_naval_battle_ctrl.sv
// Scoreboard bench for naval_battle_ctrl: stimulus queues expected
// status per confirm press, a monitor checks it after the acting edge.
module tb_naval_battle_ctrl;

   localparam int ROWS = 7;
   localparam int COLS = 5;
   localparam int MAXS = 16;
   localparam int SDIV = 2;
   localparam int N    = ROWS * COLS;

   typedef struct packed {
      logic [1:0] res;
      logic [1:0] ph;
      logic       won;
      logic [5:0] hits;
      logic [4:0] shots;
   } exp_t;

   logic          clk = 1'b0;
   logic          clr = 1'b0;
   logic          confirm = 1'b0;
   logic [N-1:0]  ship_map = '0;
   logic [2:0]    at_row = '0;
   logic [2:0]    at_col = '0;
   logic [COLS-1:0] m_col;
   logic [ROWS-1:0] m_line;
   logic [1:0]    result;
   logic [1:0]    phase;
   logic          won;
   logic [5:0]    hits;
   logic [4:0]    shots_left;

   int n_cmp = 0;
   int n_bad = 0;
   exp_t exp_q[$];

   naval_battle_ctrl #(
      .ROWS      (ROWS),
      .COLS      (COLS),
      .MAX_SHOTS (MAXS),
      .SCAN_DIV  (SDIV)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .confirm    (confirm),
      .ship_map   (ship_map),
      .at_row     (at_row),
      .at_col     (at_col),
      .m_col      (m_col),
      .m_line     (m_line),
      .result     (result),
      .phase      (phase),
      .won        (won),
      .hits       (hits),
      .shots_left (shots_left)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [1:0] r, input logic [1:0] p,
                               input logic w, input int h, input int s);
      exp_t e;
      e.res = r; e.ph = p; e.won = w;
      e.hits = 6'(h); e.shots = 5'(s);
      return e;
   endfunction

   function automatic exp_t act();
      exp_t e;
      e.res = result; e.ph = phase; e.won = won;
      e.hits = hits; e.shots = shots_left;
      return e;
   endfunction

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   // Scoreboard monitor: the DUT acts one edge after it sees a rising confirm.
   initial begin : monitor
      bit   prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(posedge clk);
         if (!clr) begin
            prev = 1'b0;
         end else if (confirm && !prev) begin
            prev = 1'b1;
            @(posedge clk);
            #1;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL press: no expectation queued, got %h", act());
            end else begin
               e = exp_q.pop_front();
               if (act() !== e) begin
                  n_bad++;
                  $display("FAIL press: got res=%b ph=%b won=%b hits=%0d shots=%0d want res=%b ph=%b won=%b hits=%0d shots=%0d",
                           result, phase, won, hits, shots_left,
                           e.res, e.ph, e.won, e.hits, e.shots);
               end
            end
         end else begin
            prev = confirm;
         end
      end
   end

   task automatic press(input int r, input int c, input exp_t e);
      @(negedge clk);
      at_row  = 3'(r);
      at_col  = 3'(c);
      confirm = 1'b1;
      exp_q.push_back(e);
      repeat (3) @(negedge clk);
      confirm = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_line(input string nm, input int col,
                           input logic [ROWS-1:0] want);
      logic [COLS-1:0] sel;
      int k;
      sel = COLS'(1) << col;
      k = 0;
      while (m_col !== sel && k < 100) begin
         @(negedge clk);
         k++;
      end
      check({nm, "_col"}, 32'(m_col), 32'(sel));
      check(nm, 32'(m_line), 32'(want));
   endtask

   task automatic chk_reset(input string nm);
      check({nm, "_status"}, 32'(act()), 32'(mk(2'b00, 2'b00, 1'b0, 0, 0)));
      check({nm, "_mcol"}, 32'(m_col), 32'(COLS'(1)));
      check({nm, "_mline"}, 32'(m_line), 32'(0));
   endtask

   localparam logic [1:0] R0 = 2'b00, RM = 2'b01, RH = 2'b10, RX = 2'b11;
   localparam logic [1:0] PI = 2'b00, PP = 2'b01, PA = 2'b10, PO = 2'b11;

   initial begin
      logic [N-1:0] s00, s64;
      int k;
      s00 = '0; s00[N-1] = 1'b1;
      s64 = '0; s64[0] = 1'b1;

      repeat (3) @(negedge clk);
      #1;
      chk_reset("reset");
      @(negedge clk);
      clr = 1'b1;
      for (int n = 1; n <= 2 * COLS * 4; n++) begin
         @(posedge clk);
         #1;
         check("scan_mcol", 32'(m_col), 32'(COLS'(1) << ((n / 4) % COLS)));
      end
      check("idle_status", 32'(act()), 32'(mk(R0, PI, 0, 0, 0)));

      // Empty fleet is rejected in PLACE.
      ship_map = '0;
      press(0, 0, mk(R0, PP, 0, 0, 0));
      press(0, 0, mk(RX, PP, 0, 0, 0));

      // Game A: single ship at (0,0), sunk by first shot.
      ship_map = s00;
      chk_line("place_line", 0, 7'b1000000);
      press(0, 0, mk(R0, PA, 0, 0, 16));
      press(0, 0, mk(RH, PO, 1, 1, 15));
      chk_line("over_line", 0, 7'b1000000);
      press(0, 0, mk(R0, PI, 0, 0, 15));

      // Game B: two ships, repeat/invalid shots, win on the last shot.
      press(0, 0, mk(R0, PP, 0, 0, 15));
      ship_map = s00 | s64;
      press(0, 0, mk(R0, PA, 0, 0, 16));
      press(1, 1, mk(RM, PA, 0, 0, 15));
      press(1, 1, mk(RX, PA, 0, 0, 15));
      chk_line("attack_line", 1, 7'b0100000);
      press(7, 0, mk(RX, PA, 0, 0, 15));
      press(0, 5, mk(RX, PA, 0, 0, 15));
      press(6, 4, mk(RH, PA, 0, 1, 14));
      for (int i = 0; i < 13; i++) begin
         press(2 + i / 5, i % 5, mk(RM, PA, 0, 1, 13 - i));
      end
      press(0, 0, mk(RH, PO, 1, 2, 0));
      press(0, 0, mk(R0, PI, 0, 0, 0));

      // Game C: budget exhausted without sinking the fleet.
      press(0, 0, mk(R0, PP, 0, 0, 0));
      ship_map = s00;
      press(0, 0, mk(R0, PA, 0, 0, 16));
      for (int i = 0; i < 16; i++) begin
         press(1 + i / 5, i % 5,
               mk(RM, (i == 15) ? PO : PA, 0, 0, 15 - i));
      end
      press(0, 0, mk(R0, PI, 0, 0, 0));

      // Game D: reset mid-game leaves nothing behind.
      press(0, 0, mk(R0, PP, 0, 0, 0));
      press(0, 0, mk(R0, PA, 0, 0, 16));
      press(1, 1, mk(RM, PA, 0, 0, 15));
      @(negedge clk);
      clr = 1'b0;
      #1;
      chk_reset("midreset");
      @(negedge clk);
      clr = 1'b1;
      press(0, 0, mk(R0, PP, 0, 0, 0));

      k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("drain", 32'(exp_q.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
